ps2_ascii_decoder: RTL and testbench

Sequential successor to the combinational scan-code lookup. Consumes raw PS/2 set-2 scan-code bytes from the keyboard receiver, tracks make/break/extended prefixes plus Shift and Caps Lock state, and translates key presses into 7-bit ASCII. Characters are queued in a parametrised FIFO and drained by a ready/valid consumer (console, VGA text buffer, UART bridge).

---
 rtl/ps2_ascii_decoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_decoder.sv
// ============================================================================
// Module   : ps2_ascii_decoder
// Purpose  : PS/2 set-2 scan codes to 7-bit ASCII with a ready/valid output FIFO.
//            Define KBD_SHIFT_MAP_EN to enable Shift/Caps Lock tracking and the
//            shifted character map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code_data,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic [6:0] ascii_data,
  output logic       shift_state,
  output logic       caps_state,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   is_make;
  logic   is_break;

  // Bit 7 flags a mapped code; bits 6:0 hold the unshifted character.
  function automatic logic [7:0] base_map(input logic [7:0] code);
    case (code)
      8'h45: return {1'b1, 7'h30};
      8'h16: return {1'b1, 7'h31};
      8'h1E: return {1'b1, 7'h32};
      8'h26: return {1'b1, 7'h33};
      8'h25: return {1'b1, 7'h34};
      8'h2E: return {1'b1, 7'h35};
      8'h36: return {1'b1, 7'h36};
      8'h3D: return {1'b1, 7'h37};
      8'h3E: return {1'b1, 7'h38};
      8'h46: return {1'b1, 7'h39};
      8'h1C: return {1'b1, 7'h61};
      8'h32: return {1'b1, 7'h62};
      8'h21: return {1'b1, 7'h63};
      8'h23: return {1'b1, 7'h64};
      8'h24: return {1'b1, 7'h65};
      8'h2B: return {1'b1, 7'h66};
      8'h34: return {1'b1, 7'h67};
      8'h33: return {1'b1, 7'h68};
      8'h43: return {1'b1, 7'h69};
      8'h3B: return {1'b1, 7'h6A};
      8'h42: return {1'b1, 7'h6B};
      8'h4B: return {1'b1, 7'h6C};
      8'h3A: return {1'b1, 7'h6D};
      8'h31: return {1'b1, 7'h6E};
      8'h44: return {1'b1, 7'h6F};
      8'h4D: return {1'b1, 7'h70};
      8'h15: return {1'b1, 7'h71};
      8'h2D: return {1'b1, 7'h72};
      8'h1B: return {1'b1, 7'h73};
      8'h2C: return {1'b1, 7'h74};
      8'h3C: return {1'b1, 7'h75};
      8'h2A: return {1'b1, 7'h76};
      8'h1D: return {1'b1, 7'h77};
      8'h22: return {1'b1, 7'h78};
      8'h35: return {1'b1, 7'h79};
      8'h1A: return {1'b1, 7'h7A};
      8'h29: return {1'b1, 7'h20};
      8'h5A: return {1'b1, 7'h0D};
      8'h66: return {1'b1, 7'h08};
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A prefix byte arriving in a break state is taken as the code byte itself.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code_data == 8'hF0)      state_d = ST_BRK;
          else if (code_data == 8'hE0) state_d = ST_EXT;
          else                         is_make = 1'b1;
        end
        ST_BRK: begin
          is_break = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT: begin
          if (code_data == 8'hF0) state_d = ST_EXT_BRK;
          else                    state_d = ST_IDLE;
        end
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  logic [7:0] base;
  logic [6:0] push_char;
  logic       push_req;

  assign base     = base_map(code_data);
  assign push_req = is_make & base[7];

`ifdef KBD_SHIFT_MAP_EN
  logic shl_q, shl_d, shr_q, shr_d, caps_held_q, caps_held_d, caps_q, caps_d;
  logic shift_now;

  function automatic logic [6:0] shifted_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h29;
      4'd1:    return 7'h21;
      4'd2:    return 7'h40;
      4'd3:    return 7'h23;
      4'd4:    return 7'h24;
      4'd5:    return 7'h25;
      4'd6:    return 7'h5E;
      4'd7:    return 7'h26;
      4'd8:    return 7'h2A;
      default: return 7'h28;
    endcase
  endfunction

  assign shift_now = shl_q | shr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
      caps_held_q <= 1'b0;
      caps_q      <= 1'b0;
    end else begin
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      caps_held_q <= caps_held_d;
      caps_q      <= caps_d;
    end
  end

  // Caps only toggles on the first make; typematic repeats see the held flag.
  always_comb begin
    shl_d       = shl_q;
    shr_d       = shr_q;
    caps_held_d = caps_held_q;
    caps_d      = caps_q;
    if (is_make) begin
      case (code_data)
        8'h12: shl_d = 1'b1;
        8'h59: shr_d = 1'b1;
        8'h58: begin
          if (!caps_held_q) caps_d = ~caps_q;
          caps_held_d = 1'b1;
        end
        default: ;
      endcase
    end else if (is_break) begin
      case (code_data)
        8'h12:   shl_d       = 1'b0;
        8'h59:   shr_d       = 1'b0;
        8'h58:   caps_held_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    push_char = base[6:0];
    if (base[6:0] >= 7'h61 && base[6:0] <= 7'h7A) begin
      if (shift_now ^ caps_q) push_char = base[6:0] - 7'h20;
    end else if (base[6:0] >= 7'h30 && base[6:0] <= 7'h39) begin
      if (shift_now) push_char = shifted_digit(base[3:0]);
    end
  end

  assign shift_state = shift_now;
  assign caps_state  = caps_q;
`else
  assign push_char   = base[6:0];
  assign shift_state = 1'b0;
  assign caps_state  = 1'b0;
`endif

  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, push_ok;

  assign ascii_valid = (count_q != '0);
  assign ascii_data  = data_q;
  assign overflow    = ovf_q;
  assign pop         = ascii_valid & ascii_ready;
  assign full        = (count_q == FULL_CNT);
  assign push_ok     = push_req & (~full | pop);

  // Head register tracks the post-edge head; a push into an emptying FIFO bypasses memory.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push_ok ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q | (push_req & full & ~pop);
    if (count_d == '0)                         data_d = data_q;
    else if (push_ok && wr_ptr_q == rd_ptr_d)  data_d = push_char;
    else                                       data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_ascii_decoder.sv
// ============================================================================
// Module   : tb_ps2_ascii_decoder
// Purpose  : Self-checking bench for ps2_ascii_decoder (FIFO_DEPTH = 4), with a
//            queue-based reference model; follows KBD_SHIFT_MAP_EN like the DUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_ascii_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       code_valid;
  logic [7:0] code_data;
  logic       ascii_ready;
  wire        ascii_valid;
  wire  [6:0] ascii_data;
  wire        shift_state;
  wire        caps_state;
  wire        overflow;

  ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_valid  (code_valid),
    .code_data   (code_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .ascii_data  (ascii_data),
    .shift_state (shift_state),
    .caps_state  (caps_state),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                               8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                               8'h35, 8'h1A};
  logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46};
  logic [7:0] specials [8] = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h29, 8'h5A, 8'h66};
  string      shifted_digits = ")!@#$%^&*(";

  int         kind [256];
  int         idx  [256];
  logic [6:0] lit  [256];

  logic [6:0] mq [$];
  bit m_ovf, m_brk, m_ext, m_shl, m_shr, m_caps, m_caps_held;

  function automatic int model_char(input logic [7:0] c);
    bit sh = 1'b0;
    bit up = 1'b0;
`ifdef KBD_SHIFT_MAP_EN
    sh = m_shl | m_shr;
    up = sh ^ m_caps;
`endif
    case (kind[c])
      1: return up ? ('h41 + idx[c]) : ('h61 + idx[c]);
      2: return sh ? int'(shifted_digits[idx[c]]) : ('h30 + idx[c]);
      3: return int'(lit[c]);
      default: return -1;
    endcase
  endfunction

  task automatic model_modifier(input logic [7:0] b, input bit make);
`ifdef KBD_SHIFT_MAP_EN
    if (b == 8'h12) m_shl = make;
    if (b == 8'h59) m_shr = make;
    if (b == 8'h58) begin
      if (make && !m_caps_held) m_caps = ~m_caps;
      m_caps_held = make;
    end
`endif
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge.
  task automatic step(input bit r, input bit v, input logic [7:0] b, input bit rdy);
    bit pop, full;
    int ch;
    rst = r; code_valid = v; code_data = b; ascii_ready = rdy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      {m_ovf, m_brk, m_ext, m_shl, m_shr, m_caps, m_caps_held} = '0;
    end else begin
      pop  = rdy && (mq.size() != 0);
      full = (mq.size() == DEPTH);
      ch   = -1;
      if (v) begin
        if (m_brk) begin
          if (!m_ext) model_modifier(b, 1'b0);
          m_brk = 1'b0;
          m_ext = 1'b0;
        end else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0 && !m_ext) m_ext = 1'b1;
        else if (m_ext) m_ext = 1'b0;
        else begin
          ch = model_char(b);
          model_modifier(b, 1'b1);
        end
      end
      if (pop) void'(mq.pop_front());
      if (ch >= 0) begin
        if (full && !pop) m_ovf = 1'b1;
        else mq.push_back(7'(ch));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    step(1, 1, 8'h1C, 1);
    step(1, 0, 8'h00, 0);
    checks++;
    if (ascii_valid !== 1'b0 || ascii_data !== 7'h00 || shift_state !== 1'b0 ||
        caps_state !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h shift=%b caps=%b ovf=%b, required all 0",
               ascii_valid, ascii_data, shift_state, caps_state, overflow);
    end
    step(0, 0, 8'h00, 0);
  endtask

  task automatic test_single_make;
    step(0, 1, 8'h1C, 0);
    checks++;
    if (ascii_valid !== 1'b1 || ascii_data !== 7'h61) begin
      errors++;
      $display("FAIL single_latency: valid=%b data=%h, required 1/61", ascii_valid, ascii_data);
    end
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'h1C, 0);
    step(0, 0, 8'h00, 1);
    checks++;
    if (ascii_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_break: valid=%b after one pop, required 0", ascii_valid);
    end
  endtask

  task automatic test_shift;
    logic [6:0] exp [3];
`ifdef KBD_SHIFT_MAP_EN
    exp = '{7'h41, 7'h21, 7'h61};
`else
    exp = '{7'h61, 7'h31, 7'h61};
`endif
    step(0, 1, 8'h12, 0);
`ifdef KBD_SHIFT_MAP_EN
    checks++;
    if (shift_state !== 1'b1) begin
      errors++;
      $display("FAIL shift_held: shift_state=%b, required 1", shift_state);
    end
`endif
    step(0, 1, 8'h1C, 0);
    step(0, 1, 8'h16, 0);
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'h12, 0);
    checks++;
    if (shift_state !== 1'b0) begin
      errors++;
      $display("FAIL shift_release: shift_state=%b, required 0", shift_state);
    end
    step(0, 1, 8'h1C, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ascii_valid !== 1'b1 || ascii_data !== exp[i]) begin
        errors++;
        $display("FAIL shift_char%0d: valid=%b data=%h, required 1/%h", i, ascii_valid, ascii_data, exp[i]);
      end
      step(0, 0, 8'h00, 1);
    end
    checks++;
    if (ascii_valid !== 1'b0) begin
      errors++;
      $display("FAIL shift_drain: valid=%b, required 0", ascii_valid);
    end
  endtask

  task automatic test_caps;
    logic [6:0] exp [2];
    logic       caps_exp;
`ifdef KBD_SHIFT_MAP_EN
    exp = '{7'h41, 7'h61};
    caps_exp = 1'b1;
`else
    exp = '{7'h61, 7'h61};
    caps_exp = 1'b0;
`endif
    step(0, 1, 8'h58, 0);
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'h58, 0);
    step(0, 1, 8'h1C, 0);
    step(0, 1, 8'h12, 0);
    step(0, 1, 8'h1C, 0);
    checks++;
    if (caps_state !== caps_exp) begin
      errors++;
      $display("FAIL caps_on: caps_state=%b, required %b", caps_state, caps_exp);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ascii_valid !== 1'b1 || ascii_data !== exp[i]) begin
        errors++;
        $display("FAIL caps_char%0d: valid=%b data=%h, required 1/%h", i, ascii_valid, ascii_data, exp[i]);
      end
      step(0, 0, 8'h00, 1);
    end
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'h12, 0);
    step(0, 1, 8'h58, 0);
    step(0, 1, 8'h58, 0);
    step(0, 1, 8'hF0, 0);
    step(0, 1, 8'h58, 0);
    checks++;
    if (caps_state !== 1'b0 || ascii_valid !== 1'b0) begin
      errors++;
      $display("FAIL caps_repeat: caps=%b valid=%b, required 0/0", caps_state, ascii_valid);
    end
  endtask

  task automatic test_extended;
    logic [7:0] seq [7] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12};
    foreach (seq[i]) step(0, 1, seq[i], 0);
    checks++;
    if (ascii_valid !== 1'b0 || shift_state !== 1'b0) begin
      errors++;
      $display("FAIL extended: valid=%b shift=%b, required 0/0", ascii_valid, shift_state);
    end
    step(0, 1, 8'h1C, 0);
    checks++;
    if (ascii_valid !== 1'b1 || ascii_data !== 7'h61) begin
      errors++;
      $display("FAIL extended_idle: valid=%b data=%h, required 1/61", ascii_valid, ascii_data);
    end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_overflow;
    int pops = 0;
    for (int i = 0; i < 5; i++) step(0, 1, 8'h16, 0);
    checks++;
    if (overflow !== 1'b1 || ascii_valid !== 1'b1 || ascii_data !== 7'h31) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b valid=%b data=%h, required 1/1/31", overflow, ascii_valid, ascii_data);
    end
    step(0, 1, 8'h16, 1);
    for (int i = 0; i < 10 && ascii_valid === 1'b1; i++) begin
      checks++;
      if (ascii_data !== 7'h31) begin
        errors++;
        $display("FAIL overflow_data: data=%h, required 31", ascii_data);
      end
      pops++;
      step(0, 0, 8'h00, 1);
    end
    checks++;
    if (pops != DEPTH || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full_pushpop: entries=%0d ovf=%b, required %0d/1", pops, overflow, DEPTH);
    end
  endtask

  task automatic test_reset_mid;
    step(0, 1, 8'h1C, 0);
    step(0, 1, 8'hF0, 0);
    step(1, 0, 8'h00, 0);
    checks++;
    if (ascii_valid !== 1'b0 || ascii_data !== 7'h00 || overflow !== 1'b0 ||
        shift_state !== 1'b0 || caps_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h ovf=%b shift=%b caps=%b, required all 0",
               ascii_valid, ascii_data, overflow, shift_state, caps_state);
    end
    step(0, 1, 8'h1C, 0);
    checks++;
    if (ascii_valid !== 1'b1 || ascii_data !== 7'h61) begin
      errors++;
      $display("FAIL reset_prefix: valid=%b data=%h, required 1/61", ascii_valid, ascii_data);
    end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_random;
    logic [7:0] b;
    bit         v, rdy;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       b = specials[$urandom_range(0, 7)];
        1:       b = letters[$urandom_range(0, 25)];
        2:       b = digits[$urandom_range(0, 9)];
        default: b = 8'($urandom);
      endcase
      rdy = ($urandom_range(0, 2) == 0);
      step((n % 250) == 249, v, b, rdy);
      checks++;
      if (ascii_valid !== (mq.size() != 0) || (mq.size() != 0 && ascii_data !== mq[0]) ||
          shift_state !== (m_shl | m_shr) || caps_state !== m_caps || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random%0d: valid=%b data=%h shift=%b caps=%b ovf=%b, required %b/%h/%b/%b/%b",
                 n, ascii_valid, ascii_data, shift_state, caps_state, overflow,
                 mq.size() != 0, (mq.size() != 0) ? mq[0] : 7'h00, m_shl | m_shr, m_caps, m_ovf);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 256; c++) begin
      kind[c] = 0; idx[c] = 0; lit[c] = 7'h00;
    end
    foreach (letters[i]) begin kind[letters[i]] = 1; idx[letters[i]] = i; end
    foreach (digits[i])  begin kind[digits[i]]  = 2; idx[digits[i]]  = i; end
    kind[8'h29] = 3; lit[8'h29] = 7'h20;
    kind[8'h5A] = 3; lit[8'h5A] = 7'h0D;
    kind[8'h66] = 3; lit[8'h66] = 7'h08;
    rst = 1'b1; code_valid = 1'b0; code_data = 8'h00; ascii_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_make();
    test_shift();
    test_caps();
    test_extended();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
